// File: rtl/output_demuxer_pkg.sv
// Shared receive-side constants: channel tags, FSM state encoding and default sizing.
// The transmitter muxer uses the same channel tag constants.
package rx_pkg;

  localparam logic [3:0] CH_IDLE  = 4'h0;
  localparam logic [3:0] CH_FIRST = 4'h1;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_CH  = 3;
  localparam int DEF_TIMEOUT = 255;

  // State value k means k channels of the current frame are staged; channel k+1 is expected next.
  localparam logic [3:0] ST_WAIT1 = 4'd0;
  localparam logic [3:0] ST_GOT1  = 4'd1;
  localparam logic [3:0] ST_GOT2  = 4'd2;

  typedef enum logic [3:0] {
    WAIT1 = ST_WAIT1,
    GOT1  = ST_GOT1,
    GOT2  = ST_GOT2
  } rx_state_e;

endpackage

// File: rtl/output_demuxer_if.sv
// Bus between the line deserializer (master) and the output demuxer (slave).
// Handshake: a byte transfers on any rising edge where in_valid=1; there is no backpressure,
// and the three output flags are single-cycle pulses aligned with the output_data update.
interface output_demuxer_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 3
);

  logic                    in_valid;
  logic [3:0]              channel;
  logic [WIDTH-1:0]        input_data;
  logic [NUM_CH*WIDTH-1:0] output_data;
  logic                    output_valid;
  logic                    seq_error;
  logic                    timeout;

  modport master (
    output in_valid, channel, input_data,
    input  output_data, output_valid, seq_error, timeout
  );

  modport slave (
    input  in_valid, channel, input_data,
    output output_data, output_valid, seq_error, timeout
  );

endinterface

// File: rtl/output_demuxer_frame_timer.sv
// Inactivity counter for a partially received frame; expired is high while the count sits at TIMEOUT.
module frame_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic arst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = run && (count_q == CW'(TIMEOUT));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/output_demuxer.sv
// Reassembles channel-tagged bytes into NUM_CH*WIDTH-bit words; publishes only complete,
// in-order frames and pulses seq_error / timeout when a partial frame is dropped.
module output_demuxer
  import rx_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   arst,
  output_demuxer_if.slave        bus,
  output rx_state_e              dbg_state_o
);

  rx_state_e               state_q, state_d;
  logic [NUM_CH*WIDTH-1:0] stage_q, stage_d;
  logic [NUM_CH*WIDTH-1:0] out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    seq_err_q, seq_err_d;
  logic                    timeout_q, timeout_d;
  logic                    accept;
  logic                    expired;
  logic                    exp_is_last;
  logic [3:0]              exp_ch;

  assign accept      = bus.in_valid && (bus.channel != CH_IDLE) && (bus.channel <= 4'(NUM_CH));
  assign exp_ch      = 4'(state_q) + 4'd1;
  assign exp_is_last = (exp_ch == 4'(NUM_CH));

  frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .arst    (arst),
    .clear   (accept || expired),
    .run     (state_q != WAIT1),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    seq_err_d = 1'b0;
    timeout_d = 1'b0;
    if (accept) begin
      if (bus.channel == exp_ch) begin
        stage_d[int'(state_q)*WIDTH +: WIDTH] = bus.input_data;
        if (exp_is_last) begin
          out_d   = stage_d;
          valid_d = 1'b1;
          state_d = WAIT1;
        end else begin
          state_d = rx_state_e'(exp_ch);
        end
      end else if (state_q != WAIT1) begin
        // A stray channel 1 is taken as the start of a fresh frame rather than discarded.
        seq_err_d = 1'b1;
        if (bus.channel == CH_FIRST) begin
          stage_d[WIDTH-1:0] = bus.input_data;
          state_d            = GOT1;
        end else begin
          state_d = WAIT1;
        end
      end
    end else if (expired) begin
      timeout_d = 1'b1;
      state_d   = WAIT1;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= WAIT1;
      stage_q   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      seq_err_q <= seq_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.output_data  = out_q;
  assign bus.output_valid = valid_q;
  assign bus.seq_error    = seq_err_q;
  assign bus.timeout      = timeout_q;
  assign dbg_state_o      = state_q;

endmodule
